// File: rtl/bcd_guess_checker.sv
// ============================================================================
// Module   : bcd_guess_checker
// Desc     : Decodes a two-digit BCD answer and grades it against the latched
//            target. The optional attempt limit is enabled by ATTEMPT_LIMIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_guess_checker #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 8,
    parameter int SCORE_W         = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         switch,
    input  logic               submit,
    input  logic [7:0]         target,
    input  logic               target_valid,
    output logic [7:0]         guess_bin,
    output logic               result_valid,
    output logic               correct,
    output logic               too_high,
    output logic               too_low,
    output logic               invalid,
    output logic [SCORE_W-1:0] score,
`ifdef ATTEMPT_LIMIT_EN
    output logic               locked,
`endif
    output logic               busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        CHECK  = 3'd2,
        SHOW   = 3'd3,
        LOCKED = 3'd4
    } state_t;

    localparam logic [7:0]         c_deb_last  = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]         c_deb_max   = 8'(DEBOUNCE_CYCLES);
    localparam logic [7:0]         c_hold_last = 8'(HOLD_CYCLES - 1);
    localparam logic [SCORE_W-1:0] c_score_max = {SCORE_W{1'b1}};

    state_t             state_q, state_d;
    logic               sync1_q, sync2_q;
    logic [7:0]         deb_q, deb_d;
    logic               accept_q, accept_d;
    logic [7:0]         tgt_q, tgt_d;
    logic [7:0]         cap_q, cap_d;
    logic [7:0]         guess_q, guess_d;
    logic               correct_q, correct_d;
    logic               high_q, high_d;
    logic               low_q, low_d;
    logic               inv_q, inv_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [7:0]         hold_q, hold_d;
`ifdef ATTEMPT_LIMIT_EN
    logic [1:0]         att_q, att_d;
`endif

    logic [7:0] w_tens, w_units, w_value, w_clamped;
    logic       w_bcd_ok;

    assign w_tens    = {4'd0, cap_q[7:4]};
    assign w_units   = {4'd0, cap_q[3:0]};
    assign w_bcd_ok  = (w_tens <= 8'd9) && (w_units <= 8'd9);
    assign w_value   = (w_tens << 3) + (w_tens << 1) + w_units;
    assign w_clamped = (target > 8'd99) ? 8'd99 : target;

    // Accept fires once, on the clock the stable-high count reaches its limit.
    always_comb begin
        deb_d    = 8'd0;
        accept_d = 1'b0;
        if (sync2_q) begin
            deb_d    = (deb_q == c_deb_max) ? deb_q : deb_q + 8'd1;
            accept_d = (deb_q == c_deb_last);
        end
    end

    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        cap_d     = cap_q;
        guess_d   = guess_q;
        correct_d = correct_q;
        high_d    = high_q;
        low_d     = low_q;
        inv_d     = inv_q;
        score_d   = score_q;
        hold_d    = hold_q;
`ifdef ATTEMPT_LIMIT_EN
        att_d     = att_q;
`endif
        if (target_valid) begin
            // A new target overrides everything, including a press on this clock.
            tgt_d     = w_clamped;
            correct_d = 1'b0;
            high_d    = 1'b0;
            low_d     = 1'b0;
            inv_d     = 1'b0;
            state_d   = ARMED;
`ifdef ATTEMPT_LIMIT_EN
            att_d     = 2'd0;
`endif
        end else begin
            case (state_q)
                ARMED: begin
                    if (accept_q) begin
                        cap_d   = switch;
                        state_d = CHECK;
                    end
                end
                CHECK: begin
                    state_d = SHOW;
                    hold_d  = 8'd0;
                    if (!w_bcd_ok) begin
                        inv_d     = 1'b1;
                        correct_d = 1'b0;
                        high_d    = 1'b0;
                        low_d     = 1'b0;
                    end else begin
                        guess_d   = w_value;
                        inv_d     = 1'b0;
                        correct_d = (w_value == tgt_q);
                        high_d    = (w_value > tgt_q);
                        low_d     = (w_value < tgt_q);
                        if ((w_value == tgt_q) && (score_q != c_score_max))
                            score_d = score_q + SCORE_W'(1);
`ifdef ATTEMPT_LIMIT_EN
                        att_d = (w_value == tgt_q) ? 2'd0 : att_q + 2'd1;
`endif
                    end
                end
                SHOW: begin
                    if (hold_q == c_hold_last) begin
`ifdef ATTEMPT_LIMIT_EN
                        state_d = (att_q == 2'd3) ? LOCKED : ARMED;
`else
                        state_d = ARMED;
`endif
                    end else begin
                        hold_d = hold_q + 8'd1;
                    end
                end
                IDLE, LOCKED: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            deb_q     <= 8'd0;
            accept_q  <= 1'b0;
            tgt_q     <= 8'd0;
            cap_q     <= 8'd0;
            guess_q   <= 8'd0;
            correct_q <= 1'b0;
            high_q    <= 1'b0;
            low_q     <= 1'b0;
            inv_q     <= 1'b0;
            score_q   <= '0;
            hold_q    <= 8'd0;
`ifdef ATTEMPT_LIMIT_EN
            att_q     <= 2'd0;
`endif
        end else begin
            state_q   <= state_d;
            sync1_q   <= submit;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            accept_q  <= accept_d;
            tgt_q     <= tgt_d;
            cap_q     <= cap_d;
            guess_q   <= guess_d;
            correct_q <= correct_d;
            high_q    <= high_d;
            low_q     <= low_d;
            inv_q     <= inv_d;
            score_q   <= score_d;
            hold_q    <= hold_d;
`ifdef ATTEMPT_LIMIT_EN
            att_q     <= att_d;
`endif
        end
    end

    assign guess_bin    = guess_q;
    assign result_valid = (state_q == SHOW);
    assign correct      = correct_q;
    assign too_high     = high_q;
    assign too_low      = low_q;
    assign invalid      = inv_q;
    assign score        = score_q;
    assign busy         = (state_q == CHECK) || (state_q == SHOW);
`ifdef ATTEMPT_LIMIT_EN
    assign locked       = (state_q == LOCKED);
`endif

endmodule

`default_nettype wire

// File: tb/tb_bcd_guess_checker.sv
// ============================================================================
// Module   : tb_bcd_guess_checker
// Desc     : Randomized self-checking bench for bcd_guess_checker against a
//            transaction-level model (ATTEMPT_LIMIT_EN adds the lockout tests).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_guess_checker;

    localparam int DEB  = 4;
    localparam int HOLD = 8;
    localparam int SW   = 7;
    // Two synchronizer flops, DEB stable clocks, then capture and check.
    localparam int LAT  = 2 + DEB + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    switch;
    logic          submit;
    logic [7:0]    target;
    logic          target_valid;
    logic [7:0]    guess_bin;
    logic          result_valid, correct, too_high, too_low, invalid, busy;
    logic [SW-1:0] score;
`ifdef ATTEMPT_LIMIT_EN
    logic          locked;
`endif

    bcd_guess_checker #(
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD),
        .SCORE_W         (SW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .switch       (switch),
        .submit       (submit),
        .target       (target),
        .target_valid (target_valid),
        .guess_bin    (guess_bin),
        .result_valid (result_valid),
        .correct      (correct),
        .too_high     (too_high),
        .too_low      (too_low),
        .invalid      (invalid),
        .score        (score),
`ifdef ATTEMPT_LIMIT_EN
        .locked       (locked),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int sub_left = 0;

    // Reference model state
    int m_tgt, m_guess, m_score, m_wrong;
    bit m_c, m_h, m_l, m_inv, m_idle, m_locked;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (sub_left > 0) begin
            sub_left--;
            if (sub_left == 0) submit = 1'b0;
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".flags"}, {28'd0, correct, too_high, too_low, invalid},
              {28'd0, m_c, m_h, m_l, m_inv});
        check({tag, ".guess"}, guess_bin, m_guess);
        check({tag, ".score"}, score, m_score);
    endtask

    task automatic model_reset();
        m_tgt = 0; m_guess = 0; m_score = 0; m_wrong = 0;
        m_c = 0; m_h = 0; m_l = 0; m_inv = 0; m_idle = 1; m_locked = 0;
    endtask

    task automatic strobe_target(input int t);
        target       = t[7:0];
        target_valid = 1'b1;
        tick();
        target_valid = 1'b0;
        m_tgt    = (t > 99) ? 99 : t;
        m_c = 0; m_h = 0; m_l = 0; m_inv = 0;
        m_idle   = 0;
        m_wrong  = 0;
        m_locked = 0;
        check_state("tv");
        check("tv.rv", result_valid, 0);
`ifdef ATTEMPT_LIMIT_EN
        check("tv.locked", locked, 0);
`endif
    endtask

    task automatic model_grade(input logic [7:0] sw);
        int tens, units, g;
        tens  = int'(sw[7:4]);
        units = int'(sw[3:0]);
        if (tens > 9 || units > 9) begin
            m_inv = 1; m_c = 0; m_h = 0; m_l = 0;
        end else begin
            g = tens * 10 + units;
            m_guess = g;
            m_inv = 0;
            m_c = (g == m_tgt);
            m_h = (g > m_tgt);
            m_l = (g < m_tgt);
            if (m_c) begin
                if (m_score < (1 << SW) - 1) m_score++;
                m_wrong = 0;
            end else begin
                m_wrong++;
            end
        end
    endtask

    // Holds submit for 10 clocks, which spans well into the verdict display.
    task automatic do_guess(input logic [7:0] sw);
        int n;
        bit seen;
        switch   = sw;
        submit   = 1'b1;
        sub_left = 10;
        if (m_idle || m_locked) begin
            seen = 0;
            repeat (24) begin
                tick();
                if (result_valid) seen = 1;
            end
            check("ignored", seen, 0);
            check_state("ignored");
            return;
        end
        n = 0;
        while (!result_valid && n < 40) begin
            tick();
            n++;
        end
        check("latency", n, LAT);
        model_grade(sw);
        check_state("verdict");
        check("busy", busy, 1);
        n = 0;
        while (result_valid && n < 40) begin
            tick();
            n++;
        end
        check("hold", n, HOLD);
`ifdef ATTEMPT_LIMIT_EN
        if (m_wrong >= 3) m_locked = 1;
        check("locked", locked, m_locked);
`endif
        check_state("after");
        seen = 0;
        repeat (6) begin
            tick();
            if (result_valid) seen = 1;
        end
        check("norepeat", seen, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, r;
        bit seen;
        logic [7:0] sw;
        rst = 1'b0; switch = 8'h00; submit = 1'b0; target = 8'h00; target_valid = 1'b0;
        model_reset();
        repeat (3) tick();
        check_state("reset");
        check("reset.rv", result_valid, 0);
        check("reset.busy", busy, 0);
        rst = 1'b1;
        tick();

        do_guess(8'h42);                  // no target yet
        strobe_target(42);
        do_guess(8'h42);
        do_guess(8'h57);
        do_guess(8'h09);
        do_guess(8'h3A);
        do_guess(8'hF0);

        // Short glitch must not register.
        switch = 8'h42;
        submit = 1'b1;
        repeat (3) tick();
        submit = 1'b0;
        seen = 0;
        repeat (15) begin
            tick();
            if (result_valid) seen = 1;
        end
        check("glitch", seen, 0);

        // New target during the display abandons it.
        switch = 8'h42; submit = 1'b1; sub_left = 10;
        n = 0;
        while (!result_valid && n < 40) begin
            tick();
            n++;
        end
        check("abort.rv", result_valid, 1);
        model_grade(8'h42);
        tick();
        strobe_target(77);
        check("abort.busy", busy, 0);
        repeat (12) tick();
        do_guess(8'h77);

`ifdef ATTEMPT_LIMIT_EN
        strobe_target(10);
        do_guess(8'h11);
        do_guess(8'h12);
        do_guess(8'h13);
        do_guess(8'h10);                  // locked out
        strobe_target(10);
        do_guess(8'h10);
`endif

        repeat (30) begin
            if ($urandom_range(0, 3) == 0) strobe_target(int'($urandom_range(0, 130)));
            r = int'($urandom_range(0, 9));
            if (r < 3)
                sw = {4'(m_tgt / 10), 4'(m_tgt % 10)};
            else if (r < 8)
                sw = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            else
                sw = {4'($urandom_range(0, 15)), 4'($urandom_range(10, 15))};
            do_guess(sw);
        end

        // Asynchronous reset in the middle of a display.
        if (m_locked) strobe_target(5);
        switch = 8'h05; submit = 1'b1; sub_left = 10;
        n = 0;
        while (!result_valid && n < 40) begin
            tick();
            n++;
        end
        check("mid.rv", result_valid, 1);
        #2 rst = 1'b0;
        #1;
        submit = 1'b0; sub_left = 0;
        model_reset();
        check_state("mid_reset");
        check("mid_reset.rv", result_valid, 0);
        check("mid_reset.busy", busy, 0);
        tick();
        rst = 1'b1;
        tick();
        do_guess(8'h05);                  // back in IDLE

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bcd_guess_checker.md
Name: bcd_guess_checker

Overview:
- Player-side counterpart to the LFSR number generator. The generator produces a target and shows it as two BCD digits; this block takes the player's two-digit BCD answer from the switches and decodes it back to binary.
- On a debounced submit press it compares the answer against the captured target and reports correct / too high / too low / invalid.
- It also keeps a running score.
- Sits between the switch bank, the submit button, the generator's target output, and the LED/display logic.

Parameters:
- DEBOUNCE_CYCLES, 4, clocks the synchronized submit must be stable high before a press is accepted (1..255)
- HOLD_CYCLES, 8, clocks the verdict is held in SHOW before re-arming (1..255)
- SCORE_W, 7, width of the correct-answer score counter

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- switch  in  8  player answer: [7:4] tens BCD digit, [3:0] units BCD digit
- submit  in  1  raw submit button, asynchronous to clk, active high
- target  in  8  binary target from generator, 0..99
- target_valid  in  1  one-cycle strobe: new target present on target
- guess_bin  out  8  binary value of the last accepted answer
- result_valid  out  1  high while a verdict is displayed (SHOW state)
- correct  out  1  verdict: guess == target
- too_high  out  1  verdict: guess > target
- too_low  out  1  verdict: guess < target
- invalid  out  1  verdict: a switch nibble > 9
- score  out  SCORE_W  count of correct answers, saturating
- busy  out  1  high in CHECK and SHOW (submit ignored)

Behaviour:
- Reset (rst low, async): state IDLE. All outputs 0. Held target, sync flops and debounce counter cleared.
- submit path:
  - 2-flop synchronizer, then debounce counter.
  - Counter increments while the synced level is 1 and clears on 0.
  - A press is accepted once, when the counter reaches DEBOUNCE_CYCLES; no repeat until the synced level returns to 0.
- target_valid: target is latched in any state, clearing the verdict flags. From IDLE it moves to ARMED. In SHOW the hold is abandoned and the FSM moves to ARMED next clock.
- Target values above 99 are clamped to 99 when latched.
- States:
  - IDLE: wait for the first target_valid; submit ignored.
  - ARMED: on an accepted press, register switch into a capture register and go to CHECK.
  - CHECK (1 clock):
    - If either nibble > 9: invalid=1, other flags 0, guess_bin unchanged.
    - Otherwise guess_bin = tens*10 + units (8-bit, max 99) and exactly one of correct/too_high/too_low is set.
    - Go to SHOW.
  - SHOW: result_valid=1 for HOLD_CYCLES clocks, then return to ARMED. Flags keep their values until the next CHECK or target_valid.
- Latency: accepted press to result_valid = 2 clocks (capture, check).
- score: +1 on entering SHOW with correct=1; saturates at 2^SCORE_W-1; cleared only by reset.
- Simultaneous events:
  - target_valid and an accepted press in ARMED on the same clock: the new target is latched and the press is discarded.
  - A press during CHECK/SHOW is discarded; it does not queue.
- A reset mid-SHOW or mid-debounce aborts immediately to IDLE.

Optional Feature:
- Macro: ATTEMPT_LIMIT_EN.
- Defined:
  - A 2-bit attempt counter, cleared on each target_valid, counts valid (non-invalid) wrong answers.
  - On the third wrong answer the FSM enters a LOCKED state after SHOW; submit is ignored until target_valid.
  - Extra output port locked (1 bit, high in LOCKED, 0 at reset).
  - A correct answer clears the counter.
- Not defined: unlimited attempts, no LOCKED state, no locked port.

Test Plan:
- Reset with rst=0 mid-operation -> all outputs 0, state IDLE; submit pulse before any target -> result_valid stays 0.
- target=42 strobed, switch=8'h42, submit held 10 clocks -> guess_bin=42, correct=1, score=1, result_valid high for exactly 8 clocks starting 2 clocks after acceptance.
- target=42, switch=8'h57 -> too_high=1, guess_bin=57; switch=8'h09 -> too_low=1, guess_bin=9.
- switch=8'h3A or 8'hF0 -> invalid=1, guess_bin unchanged, score unchanged.
- Submit glitch high for 3 clocks (DEBOUNCE_CYCLES=4) -> no verdict; submit held through CHECK/SHOW -> only one verdict; target_valid during SHOW -> flags cleared, ARMED next clock.
- With ATTEMPT_LIMIT_EN, target=10, three wrong answers 11/12/13 -> locked=1 after third SHOW; fourth submit ignored; target_valid -> locked=0.
